// File: rtl/fp16_div_seq.sv
// fp16_div_seq -- sequential IEEE half-precision divider.
// Restoring mantissa division yields one quotient bit per cycle over 13 DIV cycles.
// One NORM cycle follows, then done pulses in the cycle after NORM.
// Subnormals are not supported: any operand with bits [14:0] == 0 is zero, and
// every other operand is treated as normal with a hidden 1.
// Exponent 31 gets no special handling.
// Build option: define FP_DIV_ROUND_EN for round-to-nearest-even.
// Without FP_DIV_ROUND_EN the result is truncated and no incrementer is built.
// Latency is the same in both builds.

module fp16_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] y,
    output logic        dbz
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_NORM
    } state_t;

    // Counter value on the 13th (last) DIV cycle.
    localparam logic [3:0] DIV_LAST = 4'd12;

    state_t             state_q;
    logic [3:0]         cnt_q;
    logic [11:0]        rem_q;       // partial remainder, always < 2*divisor
    logic [11:0]        rem_d;
    logic [12:0]        quo_q;       // quotient, q[12] has weight 2^0
    logic [12:0]        quo_d;
    logic [10:0]        dvs_q;       // divisor mantissa with hidden 1
    logic signed [6:0]  ediff_q;     // ea - eb
    logic               sign_q;
    logic               za_q;
    logic               zb_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic               dbz_d;
    logic [15:0]        y_q;
    logic [15:0]        y_d;

    logic               q_bit;
    logic [10:0]        r_sub;
    logic [9:0]         man;
    logic signed [6:0]  e;

`ifdef FP_DIV_ROUND_EN
    logic               guard;
    logic               sticky;
    logic [10:0]        man_inc;
`else
    // Guard/sticky-only bit, unused when truncating.
    logic               unused_trunc_bit;
    assign unused_trunc_bit = quo_q[0];
`endif

    // One restoring-division step: compare, conditionally subtract, shift left.
    always_comb begin
        q_bit = (rem_q >= {1'b0, dvs_q});
        // When q_bit is clear the remainder is already below the divisor, so bit 11 is zero.
        r_sub = q_bit ? 11'(rem_q - {1'b0, dvs_q}) : rem_q[10:0];
        rem_d = {r_sub, 1'b0};
        quo_d = {quo_q[11:0], q_bit};
    end

    // Normalise, optionally round, then apply range and special-case selection.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        y_d   = 16'h0000;
        dbz_d = 1'b0;
        if (quo_q[12]) begin
            man = quo_q[11:2];
            e   = ediff_q + 7'sd15;
        end else begin
            man = quo_q[10:1];
            e   = ediff_q + 7'sd14;
        end
`ifdef FP_DIV_ROUND_EN
        guard   = quo_q[12] ? quo_q[1] : quo_q[0];
        sticky  = (quo_q[12] & quo_q[0]) | (rem_q != 12'd0);
        man_inc = {1'b0, man} + {10'd0, guard & (sticky | man[0])};
        if (man_inc[10]) begin
            man = 10'd0;
            e   = e + 7'sd1;
        end else begin
            man = man_inc[9:0];
        end
`endif
        if (za_q && zb_q) begin
            y_d   = 16'h7E00;
            dbz_d = 1'b1;
        end else if (zb_q) begin
            y_d   = {sign_q, 5'b11111, 10'd0};
            dbz_d = 1'b1;
        end else if (za_q) begin
            y_d   = {sign_q, 15'd0};
        end else if (e >= 7'sd31) begin
            y_d   = {sign_q, 5'b11111, 10'd0};
        end else if (e <= 7'sd0) begin
            y_d   = {sign_q, 15'd0};
        end else begin
            y_d   = {sign_q, e[4:0], man};
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rem_q   <= 12'd0;
            quo_q   <= 13'd0;
            dvs_q   <= 11'd0;
            ediff_q <= 7'sd0;
            sign_q  <= 1'b0;
            za_q    <= 1'b0;
            zb_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            y_q     <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments: every register samples pre-edge values.
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        rem_q   <= {1'b0, 1'b1, a[9:0]};
                        dvs_q   <= {1'b1, b[9:0]};
                        quo_q   <= 13'd0;
                        ediff_q <= $signed({2'b00, a[14:10]}) - $signed({2'b00, b[14:10]});
                        sign_q  <= a[15] ^ b[15];
                        za_q    <= (a[14:0] == 15'd0);
                        zb_q    <= (b[14:0] == 15'd0);
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == DIV_LAST) begin
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    y_q     <= y_d;
                    dbz_q   <= dbz_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;
    assign dbz  = dbz_q;

endmodule
